serial_parity_rx: RTL and testbench

- Serial frame receiver that sits directly upstream of the even-parity checker.
- Deserialises one asynchronous-style frame from a single-bit line: start(0), 8 data bits LSB first, parity bit, stop(1).
- Presents data[7:0] and the received parity bit as a parallel word plus a one-cycle valid strobe.
- The downstream checker consumes data/parity_bit unchanged.

---
 rtl/serial_parity_rx_if.sv | 45 ++++
 rtl/serial_parity_rx.sv | 192 +++++++++++++++++++
 tb/tb_serial_parity_rx.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_parity_rx_if.sv
// ---------------------------------------------------------------------------
// serial_parity_rx_if
//   Bundles the serial line and the parallel result of serial_parity_rx.
//
//   rx          serial line into the receiver, idle high
//   data        last received data byte, bit0 = first data bit on the line
//   parity_bit  parity bit received after data bit 7
//   valid       one-cycle strobe, data/parity_bit updated in that cycle
//   frame_err   one-cycle strobe, stop bit sampled low
//   busy        high while a frame (or a BREAK condition) is in progress
//
//   Handshake: valid and frame_err are single-cycle strobes with no ready.
//   The consumer must take data/parity_bit in the cycle valid is high; the
//   values then hold until the next valid.  valid and frame_err are never
//   high together.
//
//   Modports: master = the receiver (drives results), slave = the line
//   driver / downstream consumer.
// ---------------------------------------------------------------------------
interface serial_parity_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       parity_bit;
    logic       valid;
    logic       frame_err;
    logic       busy;

    modport master (
        input  rx,
        output data,
        output parity_bit,
        output valid,
        output frame_err,
        output busy
    );

    modport slave (
        output rx,
        input  data,
        input  parity_bit,
        input  valid,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/serial_parity_rx.sv
// ---------------------------------------------------------------------------
// serial_parity_rx
//   Receives one frame start(0), 8 data bits LSB first, parity, stop(1) from
//   a single-bit line and presents data + the received parity bit with a
//   one-cycle valid strobe.  Parity is passed through, not evaluated.
//
//   Ports:
//     clk        system clock, rising edge
//     rst        synchronous active-high reset
//     bus        serial_parity_rx_if.master (rx in; data, parity_bit,
//                valid, frame_err, busy out)
//     dbg_state  current FSM state, for observation only
//
//   Parameters:
//     CLKS_PER_BIT  clocks per serial bit (even, 4..1023)
//     CNT_W         bit-period counter width, must hold CLKS_PER_BIT-1
//
//   Optional build macro SERIAL_RX_SYNC_EN: when defined, rx goes through a
//   2-flop synchroniser (reset to 1) first, adding 2 cycles to all latencies.
//   When undefined rx must already be synchronous to clk.
// ---------------------------------------------------------------------------
module serial_parity_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 10
) (
    input  logic                clk,
    input  logic                rst,
    serial_parity_rx_if.master  bus,
    output logic [2:0]          dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(CLKS_PER_BIT - 1);

    logic rx_s;

`ifdef SERIAL_RX_SYNC_EN
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = bus.rx;
        sync2_d = sync1_q;
    end

    // Reset to the idle line level so a reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign rx_s = sync2_q;
`else
    assign rx_s = bus.rx;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [7:0]       data_q, data_d;
    logic             parity_q, parity_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        data_d    = data_q;
        parity_d  = parity_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d   = START;
                    bit_cnt_d = 3'd0;
                end
            end
            START: begin
                // Half a bit after the falling edge we are mid start bit;
                // a high line here means the low was only a glitch.
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PARITY: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d   = shift_q;
                        parity_d = par_q;
                        valid_d  = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BREAK: begin
                // Line held low: wait for it to return high before re-arming.
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            par_q     <= 1'b0;
            data_q    <= 8'h00;
            parity_q  <= 1'b0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            data_q    <= data_d;
            parity_q  <= parity_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    assign bus.data       = data_q;
    assign bus.parity_bit = parity_q;
    assign bus.valid      = valid_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = (state_q != IDLE);
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_serial_parity_rx.sv
// ---------------------------------------------------------------------------
// tb_serial_parity_rx
//   Builds a per-cycle rx waveform (directed frames then random ones), derives
//   every expected output from the frame timing rules, then replays the
//   waveform into the DUT and compares outputs on every cycle.
// ---------------------------------------------------------------------------
module tb_serial_parity_rx;

    localparam int CPB  = 4;
    localparam int HALF = CPB / 2;
    localparam int NMAX = 4000;
`ifdef SERIAL_RX_SYNC_EN
    localparam int DLY = 2;
`else
    localparam int DLY = 0;
`endif
    localparam int LAT = HALF + 10 * CPB;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] dbg_state;

    serial_parity_rx_if bus_if ();

    serial_parity_rx #(.CLKS_PER_BIT(CPB), .CNT_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if.master),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- stimulus and model storage ----------------
    logic       line   [NMAX];
    logic       rstv   [NMAX];
    logic       leff   [NMAX];
    logic       e_valid[NMAX];
    logic       e_ferr [NMAX];
    logic       e_busy [NMAX];
    logic       upd    [NMAX];
    logic [8:0] upd_val[NMAX];
    logic [8:0] e_word [NMAX];
    int         n_len;

    logic [8:0] exp_q[$];
    int         v_times[$];
    logic [8:0] v_words[$];
    int         f_times[$];

    int n_checks;
    int n_fail;
    int t_a5, t_b1, t_3c, t_55;

    task automatic chk(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- driver tasks (fill the waveform) ----------------
    task automatic put(input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            line[n_len] = b;
            rstv[n_len] = 1'b0;
            n_len++;
        end
    endtask

    task automatic add_frame(input logic [7:0] d, input logic p, input logic stop);
        put(1'b0, CPB);
        for (int k = 0; k < 8; k++) put(d[k], CPB);
        put(p, CPB);
        put(stop, CPB);
    endtask

    task automatic build_stimulus();
        int r;
        logic [7:0] d;
        n_len = 0;
        put(1'b1, 4);
        for (int i = 0; i < 4; i++) rstv[i] = 1'b1;
        put(1'b1, 6);
        // single clean frame
        t_a5 = n_len;
        add_frame(8'hA5, 1'b0, 1'b1);
        put(1'b1, 8);
        // back-to-back frames
        t_b1 = n_len;
        add_frame(8'h01, 1'b1, 1'b1);
        add_frame(8'hFF, 1'b0, 1'b1);
        put(1'b1, 8);
        // stop bit low, line held low afterwards
        t_3c = n_len;
        add_frame(8'h3C, 1'b0, 1'b0);
        put(1'b0, 20);
        put(1'b1, 8);
        // one-cycle glitch
        put(1'b0, 1);
        put(1'b1, 8);
        // frame 0x55 aborted by reset during its data bits
        put(1'b0, CPB);
        put(1'b1, CPB);
        put(1'b0, CPB);
        put(1'b1, 2);
        rstv[n_len-1] = 1'b1;
        put(1'b1, 10);
        t_55 = n_len;
        add_frame(8'h55, 1'b0, 1'b1);
        put(1'b1, 8);
        // random traffic
        for (int it = 0; it < 24; it++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                put(1'b0, 1);
                put(1'b1, int'($urandom_range(3, 6)));
            end else begin
                d = 8'($urandom_range(0, 255));
                add_frame(d, 1'($urandom_range(0, 1)), (r == 1) ? 1'b0 : 1'b1);
                if (r == 1) begin
                    put(1'b0, int'($urandom_range(0, 10)));
                    put(1'b1, int'($urandom_range(1, 6)));
                end else begin
                    put(1'b1, int'($urandom_range(0, 6)));
                end
            end
        end
        put(1'b1, 60);
    endtask

    // ---------------- behavioural model ----------------
    // Works on whole frames: find a falling edge, look at the line at the
    // mid-bit instants, and mark which cycles see valid/frame_err/busy.
    task automatic run_model();
        int pos, t, fs, s, r, q, j;
        logic ok, err;
        logic [7:0] d;
        logic [8:0] cur;
        for (int i = 0; i < n_len; i++) begin
            if (i < DLY) leff[i] = 1'b1;
            else         leff[i] = line[i-DLY];
            if (DLY > 0) begin
                if ((i >= 1 && rstv[i-1]) || (i >= 2 && rstv[i-2])) leff[i] = 1'b1;
            end
            e_valid[i] = 1'b0;
            e_ferr[i]  = 1'b0;
            e_busy[i]  = 1'b0;
            upd[i]     = 1'b0;
            upd_val[i] = 9'h000;
        end
        pos = 0;
        while (pos < n_len) begin
            if (rstv[pos] || leff[pos]) begin
                pos++;
                continue;
            end
            t   = pos;
            fs  = t + HALF;
            s   = t + LAT;
            ok  = 1'b0;
            err = 1'b0;
            if (s + 1 >= n_len) break;
            if (leff[fs]) begin
                r = fs;
            end else if (leff[s]) begin
                ok = 1'b1;
                r  = s;
            end else begin
                err = 1'b1;
                j   = s + 1;
                while (j < n_len && !leff[j]) j++;
                r = j;
            end
            q = -1;
            for (int e = t + 1; e <= r && e < n_len; e++) begin
                if (q < 0 && rstv[e]) q = e;
            end
            if (q >= 0) begin
                for (int e = t; e < q; e++) e_busy[e] = 1'b1;
                pos = q;
                continue;
            end
            for (int e = t; e < r && e < n_len; e++) e_busy[e] = 1'b1;
            if (ok) begin
                for (int k = 0; k < 8; k++) d[k] = leff[t + HALF + (k + 1) * CPB];
                e_valid[s] = 1'b1;
                upd[s]     = 1'b1;
                upd_val[s] = {leff[t + HALF + 9 * CPB], d};
                exp_q.push_back(upd_val[s]);
            end
            if (err) e_ferr[s] = 1'b1;
            pos = r + 1;
        end
        cur = 9'h000;
        for (int i = 0; i < n_len; i++) begin
            if (rstv[i])     cur = 9'h000;
            else if (upd[i]) cur = upd_val[i];
            e_word[i] = cur;
        end
    endtask

    // ---------------- per-cycle compare (outputs after edge e) ----------------
    task automatic check_cycle(input int e);
        logic [8:0] w;
        chk("valid",      e, 32'(bus_if.valid),      32'(e_valid[e]));
        chk("frame_err",  e, 32'(bus_if.frame_err),  32'(e_ferr[e]));
        chk("busy",       e, 32'(bus_if.busy),       32'(e_busy[e]));
        chk("data",       e, 32'(bus_if.data),       32'(e_word[e][7:0]));
        chk("parity_bit", e, 32'(bus_if.parity_bit), 32'(e_word[e][8]));
        if (rstv[e]) chk("reset_state", e, 32'(dbg_state), 32'd0);
        if (bus_if.valid) begin
            v_times.push_back(e);
            w = {bus_if.parity_bit, bus_if.data};
            v_words.push_back(w);
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_valid", e, 32'(w), 32'h1ff);
            end else begin
                chk("sb_word", e, 32'(w), 32'(exp_q.pop_front()));
            end
        end
        if (bus_if.frame_err) f_times.push_back(e);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bus_if.rx = 1'b1;
        rst       = 1'b1;
        build_stimulus();
        run_model();

        // pin the model against hand-computed timing
        chk("model_a5_valid", t_a5 + LAT + DLY, 32'(e_valid[t_a5 + LAT + DLY]), 32'd1);
        chk("model_a5_word",  t_a5 + LAT + DLY, 32'(upd_val[t_a5 + LAT + DLY]), 32'h0A5);

        for (int i = 0; i < n_len; i++) begin
            @(negedge clk);
            if (i > 0) check_cycle(i - 1);
            bus_if.rx = line[i];
            rst       = rstv[i];
        end
        @(negedge clk);
        check_cycle(n_len - 1);

        // hand-computed expectations for the directed frames
        if (v_times.size() >= 4) begin
            chk("a5_latency", 0, 32'(v_times[0] - t_a5), 32'(2 + 40 + DLY));
            chk("a5_word",    0, 32'(v_words[0]), 32'h0A5);
            chk("b1_latency", 1, 32'(v_times[1] - t_b1), 32'(2 + 40 + DLY));
            chk("b1_word",    1, 32'(v_words[1]), 32'h101);
            chk("b2b_gap",    2, 32'(v_times[2] - v_times[1]), 32'(11 * CPB));
            chk("ff_word",    2, 32'(v_words[2]), 32'h0FF);
            chk("55_latency", 3, 32'(v_times[3] - t_55), 32'(2 + 40 + DLY));
            chk("55_word",    3, 32'(v_words[3]), 32'h055);
        end else begin
            chk("directed_valid_count", 0, 32'(v_times.size()), 32'd4);
        end
        if (f_times.size() >= 1) begin
            chk("3c_ferr_time", 0, 32'(f_times[0] - t_3c), 32'(2 + 40 + DLY));
        end else begin
            chk("ferr_count", 0, 32'(f_times.size()), 32'd1);
        end
        chk("sb_leftover", n_len, 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
